// File: rtl/swap_sort_pkg.sv
// Shared types and sizing helpers for the swap-sort controller and its datapath.

package swap_sort_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSort,
        StDrain
    } state_e;

    // Counter width for indices 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Compare-swap cycles for a full bubble sort with no early exit.
    function automatic int unsigned sort_cycles(input int unsigned n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-and-swap built on the add/subtract exchange (mod 2^W).

module cmp_swap #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic         w_gt;
    logic [W-1:0] w_e1;
    logic [W-1:0] w_f1;
    logic [W-1:0] w_e2;

    always_comb begin
        w_gt = (x > y);
        // Wraparound in e+f cancels in the two subtractions, so overflow is harmless.
        w_e1 = x + y;
        w_f1 = w_e1 - y;
        w_e2 = w_e1 - w_f1;
        lo   = w_gt ? w_e2 : x;
        hi   = w_gt ? w_f1 : y;
    end

endmodule

// File: rtl/swap_sort_ctrl.sv
// Serial-load bubble sorter sharing one cmp_swap; drains smallest first.
// Optional SWAP_SORT_EARLY_EXIT_EN ends sorting after a pass with no exchange.

module swap_sort_ctrl
    import swap_sort_pkg::*;
#(
    parameter int unsigned W = 3,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned          CntW     = cnt_width(N);
    localparam logic [CntW-1:0]      LastIdx  = CntW'(N - 1);
    localparam logic [CntW-1:0]      LastPass = CntW'(N - 2);
    localparam logic [CntW-1:0]      One      = CntW'(1);

    state_e          r_state, w_state_d;
    logic [W-1:0]    r_mem [N];
    logic [W-1:0]    w_mem_d [N];
    logic [CntW-1:0] r_idx, w_idx_d;
    logic [CntW-1:0] r_i, w_i_d;
    logic [CntW-1:0] r_pass, w_pass_d;
    logic [CntW-1:0] r_oidx, w_oidx_d;
    logic [CntW-1:0] w_i_p1;
    logic [CntW-1:0] w_last_i;
    logic [W-1:0]    w_lo, w_hi;
    logic            w_in_fire, w_out_fire, w_pass_end, w_done;
`ifdef SWAP_SORT_EARLY_EXIT_EN
    logic            r_swapped, w_swapped_d;
    logic            w_exch;
`endif

    assign w_i_p1   = r_i + One;
    assign w_last_i = LastPass - r_pass;

    cmp_swap #(
        .W(W)
    ) u_cmp_swap (
        .x (r_mem[r_i]),
        .y (r_mem[w_i_p1]),
        .lo(w_lo),
        .hi(w_hi)
    );

    assign in_ready   = (r_state == StIdle) || (r_state == StLoad);
    assign out_valid  = (r_state == StDrain);
    assign out_data   = out_valid ? r_mem[r_oidx] : '0;
    assign busy       = (r_state != StIdle);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_pass_end = (r_i == w_last_i);

`ifdef SWAP_SORT_EARLY_EXIT_EN
    // lo differs from x only when the pair was exchanged.
    assign w_exch = (w_lo != r_mem[r_i]);
    assign w_done = (r_pass == LastPass) || !(r_swapped || w_exch);
`else
    assign w_done = (r_pass == LastPass);
`endif

    always_comb begin
        w_state_d = r_state;
        w_mem_d   = r_mem;
        w_idx_d   = r_idx;
        w_i_d     = r_i;
        w_pass_d  = r_pass;
        w_oidx_d  = r_oidx;
`ifdef SWAP_SORT_EARLY_EXIT_EN
        w_swapped_d = r_swapped;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_in_fire) begin
                    w_mem_d[0] = in_data;
                    w_idx_d    = One;
                    w_state_d  = StLoad;
                end
            end
            StLoad: begin
                if (w_in_fire) begin
                    w_mem_d[r_idx] = in_data;
                    if (r_idx == LastIdx) begin
                        w_state_d = StSort;
                        w_i_d     = '0;
                        w_pass_d  = '0;
`ifdef SWAP_SORT_EARLY_EXIT_EN
                        w_swapped_d = 1'b0;
`endif
                    end else begin
                        w_idx_d = r_idx + One;
                    end
                end
            end
            StSort: begin
                w_mem_d[r_i]    = w_lo;
                w_mem_d[w_i_p1] = w_hi;
`ifdef SWAP_SORT_EARLY_EXIT_EN
                w_swapped_d = r_swapped || w_exch;
`endif
                if (w_pass_end) begin
                    w_i_d = '0;
`ifdef SWAP_SORT_EARLY_EXIT_EN
                    w_swapped_d = 1'b0;
`endif
                    if (w_done) begin
                        w_state_d = StDrain;
                        w_oidx_d  = '0;
                    end else begin
                        w_pass_d = r_pass + One;
                    end
                end else begin
                    w_i_d = w_i_p1;
                end
            end
            StDrain: begin
                if (w_out_fire) begin
                    if (r_oidx == LastIdx) begin
                        w_state_d = StIdle;
                        w_oidx_d  = '0;
                    end else begin
                        w_oidx_d = r_oidx + One;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_i     <= '0;
            r_pass  <= '0;
            r_oidx  <= '0;
            for (int k = 0; k < N; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
            r_i     <= w_i_d;
            r_pass  <= w_pass_d;
            r_oidx  <= w_oidx_d;
            r_mem   <= w_mem_d;
        end
    end

`ifdef SWAP_SORT_EARLY_EXIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swapped <= 1'b0;
        end else begin
            r_swapped <= w_swapped_d;
        end
    end
`endif

endmodule

// File: tb/tb_swap_sort_ctrl.sv
// Directed bench for swap_sort_ctrl (W=3, N=4) with hand-computed sorted outputs.

module tb_swap_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic       busy;

    int checks   = 0;
    int failures = 0;

`ifdef SWAP_SORT_EARLY_EXIT_EN
    localparam int LatSorted = 3;
`else
    localparam int LatSorted = 6;
`endif

    swap_sort_ctrl #(
        .W(3),
        .N(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load4(input logic [2:0] a, b, c, d);
        logic [2:0] w[4];
        w = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = w[k];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // pat bit t gives out_ready for drain cycle t; cycles past bit 5 use 1.
    task automatic run_job(input logic [2:0] a, b, c, d, input logic [2:0] e0, e1, e2, e3,
                           input int lat, input logic [5:0] pat, input bit poke);
        logic [2:0] e[4];
        int cnt;
        int k;
        int t;
        e = '{e0, e1, e2, e3};
        load4(a, b, c, d);
        in_valid = poke;
        in_data  = 3'd7;
        cnt = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid) break;
            if (poke) chk("in_ready_sort", in_ready, 0);
            cnt++;
            if (cnt > 40) break;
        end
        in_valid = 1'b0;
        chk("latency", cnt, lat);
        k = 0;
        t = 0;
        while (k < 4 && t < 20) begin
            chk("out_valid_drain", out_valid, 1);
            chk("out_data", out_data, e[k]);
            out_ready = (t < 6) ? pat[t] : 1'b1;
            @(posedge clk);
            if (out_ready) k++;
            t++;
            @(negedge clk);
        end
        chk("drain_count", k, 4);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
        chk("out_valid_after", out_valid, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(3'd5, 3'd3, 3'd7, 3'd1, 3'd1, 3'd3, 3'd5, 3'd7, 6, 6'b111111, 1'b0);
        run_job(3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, LatSorted, 6'b111111, 1'b0);
        run_job(3'd7, 3'd6, 3'd7, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 6, 6'b111111, 1'b0);
        run_job(3'd4, 3'd4, 3'd0, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 6, 6'b111111, 1'b1);
        run_job(3'd2, 3'd1, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 6, 6'b111001, 1'b0);

        // Abort on the second SORT cycle.
        load4(3'd5, 3'd3, 3'd7, 3'd1);
        chk("busy_sort", busy, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_out_valid", out_valid, 0);
        chk("post_abort_busy", busy, 0);
        run_job(3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 6, 6'b111111, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
